// File: rtl/seq_det_pkg.sv
// Shared types, constants and helpers for the programmable sequence detector.
package seq_det_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_e;

  localparam int unsigned SEQ_MIN_LEN         = 2;
  localparam int unsigned SEQ_DEFAULT_MAX_LEN = 8;

  // A pattern length is usable only when it lies in SEQ_MIN_LEN..max.
  function automatic logic len_legal(input int unsigned len, input int unsigned max);
    return (len >= SEQ_MIN_LEN) && (len <= max);
  endfunction

endpackage

// File: rtl/seq_det_cmp.sv
// Masked compare of the post-shift history against the loaded pattern;
// only the low `len` bits take part, higher pattern bits are don't-care.
module seq_det_cmp
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = SEQ_DEFAULT_MAX_LEN,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic [MAX_LEN-1:0] hist_next,
  input  logic [MAX_LEN-1:0] pat,
  input  logic [LEN_W-1:0]   len,
  output logic               match
);

  logic [MAX_LEN-1:0] mask;

  // NOTE: every bit of a combinational output is given a value before any
  // conditional logic, so no path can leave it unassigned and infer a latch.
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len);
    end
  end

  assign match = (((hist_next ^ pat) & mask) == '0);

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial sequence detector with overlap control.
// Define SEQ_DET_MATCH_COUNT_EN to build the saturating match counter.
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int unsigned MAX_LEN = SEQ_DEFAULT_MAX_LEN,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1),
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               seq_in,
  input  logic               seq_valid,
  input  logic               load,
  input  logic [MAX_LEN-1:0] pat_in,
  input  logic [LEN_W-1:0]   len_in,
  input  logic               overlap,
  output logic               seq_out,
  output logic               armed,
  output logic [CNT_W-1:0]   match_count
);

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);

  seq_state_e         state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               seq_out_q, seq_out_d;

  logic [MAX_LEN-1:0] hist_next;
  logic [LEN_W-1:0]   fill_next;
  logic               cmp_hit;

  // Oldest bit falls off the top; fill stops counting once the window is full.
  assign hist_next = (hist_q << 1) | MAX_LEN'(seq_in);
  assign fill_next = (fill_q == FILL_MAX) ? fill_q : fill_q + LEN_W'(1);

  seq_det_cmp #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_cmp (
    .hist_next (hist_next),
    .pat       (pat_q),
    .len       (len_q),
    .match     (cmp_hit)
  );

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    len_d     = len_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    seq_out_d = 1'b0;

    // A load restarts the search and swallows any bit or match on the same edge.
    if (load) begin
      pat_d   = pat_in;
      len_d   = len_in;
      hist_d  = '0;
      fill_d  = '0;
      state_d = len_legal(32'(len_in), MAX_LEN) ? RUN : IDLE;
    end else if ((state_q == RUN) && seq_valid) begin
      hist_d = hist_next;
      fill_d = fill_next;
      if ((fill_next >= len_q) && cmp_hit) begin
        seq_out_d = 1'b1;
        if (!overlap) begin
          fill_d = '0;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      hist_q    <= '0;
      fill_q    <= '0;
      seq_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      seq_out_q <= seq_out_d;
    end
  end

  assign seq_out = seq_out_q;
  assign armed   = (state_q == RUN);

`ifdef SEQ_DET_MATCH_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (seq_out_d && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_count = cnt_q;
`else
  assign match_count = '0;
`endif

endmodule

// File: doc/seq_detector_prog.md
# seq_detector_prog

Runtime-programmable serial sequence detector: the successor to the fixed 5-bit "10110" detector. Pattern and length are loaded at run time, overlapping or non-overlapping detection is selectable, and input bits are qualified by a valid strobe. The block sits on a serial bit stream and pulses `seq_out` once per detected occurrence. An optional saturating match counter can be compiled in.

## Interface
- `MAX_LEN`, 8: maximum pattern length in bits, 2..32.
- `LEN_W`, $clog2(MAX_LEN+1): width of the length field.
- `CNT_W`, 16: match counter width.

Ports:
- `clock` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `seq_in` in 1: serial data bit.
- `seq_valid` in 1: `seq_in` is sampled only when high.
- `load` in 1: one-cycle strobe; captures `pat_in`/`len_in`.
- `pat_in` in MAX_LEN: pattern, right-aligned. Bit `[len-1]` is the first bit received, bit `[0]` the last.
- `len_in` in LEN_W: pattern length.
- `overlap` in 1: 1 = overlapping detection, 0 = non-overlapping. Sampled every valid bit.
- `seq_out` out 1: registered one-cycle match pulse.
- `armed` out 1: high when a legal pattern is loaded.
- `match_count` out CNT_W: saturating count of matches.

## Operation
- FSM has two states, IDLE and RUN.
- IDLE: entered at reset, or on a `load` with an illegal length (`len_in` < 2 or > MAX_LEN). `seq_out`=0, `armed`=0, input bits ignored.
- RUN: entered on a `load` with a legal length. `armed`=1.
- Datapath:
  - `hist`: MAX_LEN-bit shift register; each valid bit shifts in at LSB.
  - `fill`: count of valid bits since the last restart, saturating at MAX_LEN.
- Match condition, evaluated on each valid bit in RUN using the post-shift history: `fill_next` ≥ len, and the low len bits of `hist_next` equal the low len bits of the pattern.
- After a match:
  - `overlap`=1: `fill` is kept, so a suffix of the match can begin the next match.
  - `overlap`=0: `fill` is cleared to 0; `hist` is still written.
- `load` in any state: captures pattern/len, clears `hist` and `fill`, and resets `match_count` if it is compiled in. If `seq_valid` is high in the same cycle, that bit is discarded.
- Pattern bits above len-1 are don't-care.
- Reset values: `seq_out`=0, `armed`=0, `match_count`=0, `hist`=0, `fill`=0, pattern=0, len=0, state=IDLE.

## Timing
- Latency: `seq_out` is high for exactly one cycle, in the cycle after the edge that sampled the final pattern bit.
- Back-to-back matches give consecutive pulses, e.g. pattern "11", len 2, overlap=1, input 1,1,1.
- `seq_valid` low: `hist`, `fill` and `seq_out` generation freeze; `seq_out` is 0 in the following cycle.
- `reset` dominates `load` and `seq_valid` in the same cycle.
- Reset mid-sequence: a partial match is discarded; no pulse is produced from bits sampled before reset.
- `overlap` changes take effect on the next valid bit.
- `load` during a pending match: the match completed on the same edge is discarded, so `seq_out` is 0 next cycle.

## Configuration
- `SEQ_DET_MATCH_COUNT_EN` defined: `match_count` increments by 1 on every cycle `seq_out` is set, and saturates at 2^CNT_W−1 with no wrap. It is cleared by reset and by `load`.
- Not defined: the `match_count` port remains but is tied to 0, and no counter flops are synthesised.

## Structure
- Shared package `seq_det_pkg`:
  - state enum `{IDLE, RUN}`.
  - constants `SEQ_MIN_LEN`=2 and the default `MAX_LEN`.
  - a function `len_legal(len, max)`.
- One sub-module, `seq_det_cmp`: combinational masked compare of `hist_next` against the pattern under the len mask. It is the natural split point for widening later.
- Top level holds the FSM, history, fill, output and counter registers.

## Test plan
- Legacy pattern:
  - Stimulus: load `pat_in`=8'b0001_0110, len 5, overlap=1; stream 1,0,1,1,0 with `seq_valid` high.
  - Required: one `seq_out` pulse, in the cycle after the fifth bit; `match_count`=1.
- Overlap vs non-overlap:
  - Stimulus: pattern "101", len 3; stream 1,0,1,0,1.
  - Required: overlap=1 gives pulses after bits 3 and 5; overlap=0 gives a pulse after bit 3 only.
- Valid gaps:
  - Stimulus: stream 1,0,1,1,0 with `seq_valid` low for 3 cycles between bits 2 and 3.
  - Required: exactly one pulse, after bit 5.
- Illegal load:
  - Stimulus: `len_in`=1, then `len_in`=MAX_LEN+1.
  - Required: `armed`=0 and no pulses for any input.
  - Stimulus: a subsequent legal load.
  - Required: `armed`=1 the next cycle.
- Reset / reload mid-sequence:
  - Stimulus: after 4 of 5 matching bits, assert `reset` (or `load` of the same pattern); then feed the last bit only.
  - Required: no pulse.
- Counter saturation, with `SEQ_DET_MATCH_COUNT_EN` and CNT_W=4:
  - Stimulus: 20 matches with pattern "11", overlap=1.
  - Required: `match_count` holds at 15.
  - Without the macro: `match_count` stays 0.
